result_uart_framer: RTL and testbench

//  Downstream consumer of the float-to-ASCII converter: latches its sign char, 6 integer

---
 rtl/calc_ascii_pkg.sv | 15 +
 rtl/frame_byte_sel.sv | 32 +++
 rtl/result_uart_framer.sv | 78 +++++++
 tb/tb_result_uart_framer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_ascii_pkg.sv
// calc_ascii_pkg: ASCII constants, digit counts and framer FSM states shared along the calculator result path
package calc_ascii_pkg;
  localparam int INT_DIGITS = 6;
  localparam int FRAC_DIGITS = 6;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_DOT = 8'h2E;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_O = 8'h4F;
  localparam logic [7:0] CH_V = 8'h56;
  localparam logic [7:0] CH_F = 8'h46;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;
endpackage

// File: rtl/frame_byte_sel.sv
// frame_byte_sel: maps a logical frame index to the outgoing byte and flags the final byte of the frame
module frame_byte_sel
  import calc_ascii_pkg::*;
#(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic [4:0]  idx,
  input  logic [7:0]  sign_char,
  input  logic [47:0] int_chars,
  input  logic [47:0] frac_chars,
  input  logic        ok,
  output logic [7:0]  data,
  output logic        last
);
  logic [7:0] f [16];
  always_comb begin
    f[0] = sign_char;
    for (int i = 0; i < INT_DIGITS; i++) f[1+i] = int_chars[47-8*i -: 8];
    f[7] = CH_DOT;
    for (int i = 0; i < FRAC_DIGITS; i++) f[8+i] = frac_chars[47-8*i -: 8];
    f[14] = CH_CR;
    f[15] = CH_LF;
  end
  assign data = idx[4] ? 8'h00 :
                ok ? f[idx[3:0]] :
                idx == 5'd0 ? CH_O :
                idx == 5'd1 ? CH_V :
                idx == 5'd2 ? CH_F :
                idx == 5'd3 ? CH_CR :
                idx == 5'd4 ? CH_LF : 8'h00;
  assign last = idx == (ok ? (SEND_CRLF ? 5'd15 : 5'd13) : (SEND_CRLF ? 5'd4 : 5'd2));
endmodule

// File: rtl/result_uart_framer.sv
// result_uart_framer: latches a converted result and streams it to the UART TX as "<sign>IIIIII.FFFFFF\r\n" or "OVF\r\n"
module result_uart_framer
  import calc_ascii_pkg::*;
#(
  parameter bit STRIP_ZEROS = 1'b0,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  sign_char,
  input  logic [47:0] int_chars,
  input  logic [47:0] frac_chars,
  input  logic        value_ok,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);
  state_t state, state_n;
  logic [4:0] idx, idx_n;
  logic [7:0] sign_q;
  logic [47:0] int_q, frac_q;
  logic ok_q, lead, acc, last;
  logic [2:0] zoff;
  logic [7:0] sel_byte;
  frame_byte_sel #(.SEND_CRLF(SEND_CRLF)) u_sel (
    .idx(idx),
    .sign_char(sign_q),
    .int_chars(int_q),
    .frac_chars(frac_q),
    .ok(ok_q),
    .data(sel_byte),
    .last(last)
  );
  // Leading '0' count over the first five integer digits; the units digit is always kept
  always_comb begin
    zoff = '0;
    lead = 1'b1;
    for (int i = 0; i < INT_DIGITS-1; i++) begin
      lead = lead & (int_q[47-8*i -: 8] == CH_ZERO);
      zoff = zoff + {2'b00, lead};
    end
  end
  assign acc = state == SEND && tx_ready;
  always_comb begin
    state_n = state == IDLE ? (start ? LOAD : IDLE) :
              state == LOAD ? SEND :
              state == SEND ? ((acc && last) ? FIN : SEND) : IDLE;
    idx_n = state == LOAD ? 5'd0 :
            !acc ? idx :
            (STRIP_ZEROS && ok_q && idx == 5'd0) ? 5'd1 + {2'b00, zoff} : idx + 5'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      sign_q <= '0;
      int_q <= '0;
      frac_q <= '0;
      ok_q <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      if (state == IDLE && start) begin
        sign_q <= sign_char;
        int_q <= int_chars;
        frac_q <= frac_chars;
        ok_q <= value_ok;
      end
    end
  end
  assign tx_valid = state == SEND;
  assign tx_data = tx_valid ? sel_byte : 8'h00;
  assign busy = state == LOAD || state == SEND;
  assign done = state == FIN;
endmodule

// File: tb/tb_result_uart_framer.sv
// tb_result_uart_framer: directed tests of the framer with and without leading-zero stripping
module tb_result_uart_framer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0, tx_ready = 1'b1, value_ok = 1'b1;
  logic [7:0] sign_char = 8'h2B;
  logic [47:0] int_chars = "000123", frac_chars = "450000";
  logic [7:0] d0, d1, tx_data;
  logic v0, v1, b0, b1, dn0, dn1, tx_valid, busy, done;
  int total = 0, bad = 0;
  string crlf;

  result_uart_framer #(.STRIP_ZEROS(1'b0), .SEND_CRLF(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .sign_char(sign_char),
    .int_chars(int_chars), .frac_chars(frac_chars), .value_ok(value_ok),
    .tx_data(d0), .tx_valid(v0), .tx_ready(tx_ready), .busy(b0), .done(dn0)
  );
  result_uart_framer #(.STRIP_ZEROS(1'b1), .SEND_CRLF(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .sign_char(sign_char),
    .int_chars(int_chars), .frac_chars(frac_chars), .value_ok(value_ok),
    .tx_data(d1), .tx_valid(v1), .tx_ready(tx_ready), .busy(b1), .done(dn1)
  );
  assign tx_data = sel ? d1 : d0;
  assign tx_valid = sel ? v1 : v0;
  assign busy = sel ? b1 : b0;
  assign done = sel ? dn1 : dn0;

  always #5 clk = ~clk;

  function automatic string vis(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      if (s[i] == 8'h0D) r = {r, "<CR>"};
      else if (s[i] == 8'h0A) r = {r, "<LF>"};
      else r = $sformatf("%s%c", r, s[i]);
    return r;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records accepted bytes until done; iteration 0 is the cycle right after the start edge
  task automatic capture(input bit rnd, input int start_at, output string got, output int lat,
                         output int done_iter, output int ndone, output int unstable, output int busy_low);
    logic [7:0] prev = 8'h00;
    bit held = 1'b0;
    got = ""; lat = -1; done_iter = -1; ndone = 0; unstable = 0; busy_low = 0;
    tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      if (tx_valid && lat < 0) lat = it;
      if (held && !(tx_valid && tx_data == prev)) unstable++;
      held = tx_valid && !tx_ready;
      prev = tx_data;
      if (tx_valid && tx_ready) got = $sformatf("%s%c", got, tx_data);
      if (done) begin
        ndone++;
        done_iter = it;
        break;
      end
      if (!busy) busy_low++;
      @(posedge clk); #1;
      start = (it == start_at);
      if (it == start_at) begin
        sign_char = 8'h2D; int_chars = "999999"; frac_chars = "888888"; value_ok = 1'b0;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    sel = 1'b0; #1;
    total++;
    if ({tx_valid, busy, done, tx_data} !== 11'b0) begin
      bad++; $display("FAIL reset_u0 got=%b exp=0", {tx_valid, busy, done, tx_data});
    end
    sel = 1'b1; #1;
    total++;
    if ({tx_valid, busy, done, tx_data} !== 11'b0) begin
      bad++; $display("FAIL reset_u1 got=%b exp=0", {tx_valid, busy, done, tx_data});
    end
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_plain();
    string got, exp;
    int lat, di, nd, un, bl;
    sel = 1'b0; sign_char = 8'h2B; int_chars = "000123"; frac_chars = "450000"; value_ok = 1'b1;
    exp = {"+000123.450000", crlf};
    pulse_start();
    capture(1'b0, -1, got, lat, di, nd, un, bl);
    total++;
    if (got != exp) begin bad++; $display("FAIL plain_bytes got=%s exp=%s", vis(got), vis(exp)); end
    total++;
    if (lat !== 1) begin bad++; $display("FAIL plain_latency got=%0d exp=1", lat); end
    total++;
    if (di !== 17 || nd !== 1) begin bad++; $display("FAIL plain_done got=iter%0d/n%0d exp=iter17/n1", di, nd); end
    total++;
    if (bl !== 0) begin bad++; $display("FAIL plain_busy got=%0d low cycles exp=0", bl); end
    @(negedge clk);
    total++;
    if ({done, busy, tx_valid} !== 3'b000) begin
      bad++; $display("FAIL plain_after_fin got=%b exp=000", {done, busy, tx_valid});
    end
  endtask

  task automatic test_strip();
    string got, exp;
    int lat, di, nd, un, bl;
    sel = 1'b1; sign_char = 8'h2B; int_chars = "000123"; frac_chars = "450000"; value_ok = 1'b1;
    exp = {"+123.450000", crlf};
    pulse_start();
    capture(1'b0, -1, got, lat, di, nd, un, bl);
    total++;
    if (got != exp) begin bad++; $display("FAIL strip_123 got=%s exp=%s", vis(got), vis(exp)); end
    total++;
    if (di !== 14 || nd !== 1) begin bad++; $display("FAIL strip_123_done got=iter%0d/n%0d exp=iter14/n1", di, nd); end
    int_chars = "000000";
    exp = {"+0.450000", crlf};
    pulse_start();
    capture(1'b0, -1, got, lat, di, nd, un, bl);
    total++;
    if (got != exp) begin bad++; $display("FAIL strip_zero got=%s exp=%s", vis(got), vis(exp)); end
    sign_char = 8'h2D; int_chars = "100200"; frac_chars = "000007";
    exp = {"-100200.000007", crlf};
    pulse_start();
    capture(1'b0, -1, got, lat, di, nd, un, bl);
    total++;
    if (got != exp) begin bad++; $display("FAIL strip_none got=%s exp=%s", vis(got), vis(exp)); end
    sel = 1'b0;
  endtask

  task automatic test_ovf();
    string got, exp;
    int lat, di, nd, un, bl;
    exp = {"OVF", crlf};
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); sign_char = 8'h2D; int_chars = "000123"; frac_chars = "450000"; value_ok = 1'b0;
      pulse_start();
      capture(1'b0, -1, got, lat, di, nd, un, bl);
      total++;
      if (got != exp) begin bad++; $display("FAIL ovf_bytes_%0d got=%s exp=%s", s, vis(got), vis(exp)); end
      total++;
      if (di !== 6 || nd !== 1) begin bad++; $display("FAIL ovf_done_%0d got=iter%0d/n%0d exp=iter6/n1", s, di, nd); end
    end
    sel = 1'b0; value_ok = 1'b1;
  endtask

  task automatic test_stall();
    string got, exp;
    int lat, di, nd, un, bl;
    sel = 1'b0; sign_char = 8'h2B; int_chars = "000123"; frac_chars = "450000"; value_ok = 1'b1;
    exp = {"+000123.450000", crlf};
    for (int r = 0; r < 3; r++) begin
      pulse_start();
      capture(1'b1, -1, got, lat, di, nd, un, bl);
      total++;
      if (got != exp) begin bad++; $display("FAIL stall_bytes_%0d got=%s exp=%s", r, vis(got), vis(exp)); end
      total++;
      if (un !== 0 || nd !== 1) begin bad++; $display("FAIL stall_hold_%0d got=unstable%0d/n%0d exp=0/1", r, un, nd); end
    end
  endtask

  task automatic test_mid_start();
    string got, exp;
    int lat, di, nd, un, bl;
    sel = 1'b0; sign_char = 8'h2B; int_chars = "000123"; frac_chars = "450000"; value_ok = 1'b1;
    exp = {"+000123.450000", crlf};
    pulse_start();
    capture(1'b0, 5, got, lat, di, nd, un, bl);
    total++;
    if (got != exp) begin bad++; $display("FAIL mid_start_bytes got=%s exp=%s", vis(got), vis(exp)); end
    total++;
    if (bl !== 0 || nd !== 1 || di !== 17) begin
      bad++; $display("FAIL mid_start_busy got=low%0d/n%0d/iter%0d exp=0/1/17", bl, nd, di);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_start_queued got=%b exp=0", busy); end
    sign_char = 8'h2B; int_chars = "000123"; frac_chars = "450000"; value_ok = 1'b1;
  endtask

  task automatic test_reset_mid();
    string got, exp;
    int lat, di, nd, un, bl, nd_rst;
    sel = 1'b0; tx_ready = 1'b1;
    pulse_start();
    repeat (9) @(negedge clk);
    total++;
    if (!(tx_valid && tx_data == 8'h2E)) begin
      bad++; $display("FAIL rst_byte7 got=%b/%h exp=1/2e", tx_valid, tx_data);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({tx_valid, busy, done, tx_data} !== 11'b0) begin
      bad++; $display("FAIL rst_async got=%b exp=0", {tx_valid, busy, done, tx_data});
    end
    nd_rst = 0;
    repeat (3) begin @(negedge clk); if (done) nd_rst++; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (done || tx_valid) nd_rst++; end
    total++;
    if (nd_rst !== 0) begin bad++; $display("FAIL rst_no_done got=%0d exp=0", nd_rst); end
    sign_char = 8'h2D; int_chars = "000042"; frac_chars = "000001";
    exp = {"-000042.000001", crlf};
    pulse_start();
    capture(1'b0, -1, got, lat, di, nd, un, bl);
    total++;
    if (got != exp || nd !== 1) begin
      bad++; $display("FAIL rst_fresh got=%s/n%0d exp=%s/n1", vis(got), nd, vis(exp));
    end
  endtask

  initial begin
    crlf = $sformatf("%c%c", 8'h0D, 8'h0A);
    test_reset();
    test_plain();
    test_strip();
    test_ovf();
    test_stall();
    test_mid_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
